// File: rtl/memoria_dados.sv
// memoria_dados: single-port word memory behind a valid/ready request channel
// and a valid/ready response channel, with a fixed number of wait states per
// access.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset; clears the FSM and every word
//   req_valid  request present              req_ready  accepting (IDLE only)
//   req_we     1 = write, 0 = read          req_addr   word address
//   req_wdata  write data                   req_be     byte-lane write enables
//   rsp_valid  response present             rsp_ready  consumer takes response
//   rsp_rdata  read data (0 for writes and out-of-range accesses)
//   rsp_err    address >= DEPTH
//   busy       transaction in flight (WAIT or RESP)
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | ready for a request; req_ready high
// S_WAIT | request registered; counter counts wait states down to 0
// S_RESP | response registered and held until rsp_ready
module memoria_dados #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 32,
   parameter int WAIT   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [DATA_W/8-1:0]   req_be,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_err,
   output logic                  busy
);

   localparam int NB = DATA_W / 8;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]          state;
   logic [3:0]          cnt;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [NB-1:0]       be_q;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic                in_range;

   // One extra bit so DEPTH == 2**ADDR_W compares correctly.
   assign in_range  = ({1'b0, addr_q} < (ADDR_W + 1)'(DEPTH));
   assign req_ready = (state == S_IDLE) && !rst;
   assign busy      = (state == S_WAIT) || (state == S_RESP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  be_q    <= req_be;
                  cnt     <= 4'(WAIT);
                  state   <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  // Access edge: storage and response registers update together.
                  state     <= S_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= !in_range;
                  rsp_rdata <= (!we_q && in_range) ? mem[addr_q] : '0;
                  if (we_q && in_range) begin
                     for (int b = 0; b < NB; b++) begin
                        if (be_q[b]) begin
                           mem[addr_q][8*b +: 8] <= wdata_q[8*b +: 8];
                        end
                     end
                  end
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memoria_dados.sv
// Self-checking bench for memoria_dados: instance a (DEPTH=24, WAIT=2) takes
// the vector table, random traffic, backpressure and mid-transaction reset;
// instance b (DEPTH=24, WAIT=0) covers zero-wait latency and throughput.
module tb_memoria_dados;

   localparam int DW = 64;
   localparam int AW = 5;
   localparam int DP = 24;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          a_req_valid = 1'b0, a_req_ready, a_req_we = 1'b0;
   logic [AW-1:0] a_req_addr = '0;
   logic [DW-1:0] a_req_wdata = '0;
   logic [7:0]    a_req_be = '0;
   logic          a_rsp_valid, a_rsp_ready = 1'b1, a_rsp_err, a_busy;
   logic [DW-1:0] a_rsp_rdata;

   logic          b_req_valid = 1'b0, b_req_ready, b_req_we = 1'b0;
   logic [AW-1:0] b_req_addr = '0;
   logic [DW-1:0] b_req_wdata = '0;
   logic [7:0]    b_req_be = '0;
   logic          b_rsp_valid, b_rsp_ready = 1'b1, b_rsp_err, b_busy;
   logic [DW-1:0] b_rsp_rdata;

   memoria_dados #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .WAIT(2)) dut_a (
      .clk(clk), .rst(rst),
      .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
      .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
      .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
      .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err), .busy(a_busy)
   );

   memoria_dados #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .WAIT(0)) dut_b (
      .clk(clk), .rst(rst),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
      .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
      .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
      .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .busy(b_busy)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: plain array of words, byte-granular merge.
   logic [DW-1:0] mdl [DP];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < DP; i++) mdl[i] = '0;
   endtask

   task automatic model_access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                               input logic [7:0] be, output logic [DW-1:0] rd, output logic err);
      int a;
      a = int'(addr);
      rd = '0;
      err = (a >= DP);
      if (!err) begin
         if (we) begin
            for (int k = 0; k < 8; k++)
               if (be[k]) mdl[a][8*k +: 8] = wdata[8*k +: 8];
         end else begin
            rd = mdl[a];
         end
      end
   endtask

   // One complete transaction on instance a with rsp_ready held high.
   // lat counts rising edges from acceptance to the edge that raises rsp_valid.
   task automatic txn_a(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [7:0] be, output logic [DW-1:0] rd, output logic err, output int lat);
      @(negedge clk);
      a_req_valid = 1'b1;
      a_req_we    = we;
      a_req_addr  = addr;
      a_req_wdata = wdata;
      a_req_be    = be;
      a_rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      a_req_valid = 1'b0;
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!a_rsp_valid && lat < 40);
      rd  = a_rsp_rdata;
      err = a_rsp_err;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [7:0]    be;
      logic [DW-1:0] exp_rd;
      logic          exp_err;
   } vec_t;

   vec_t vecs[12];

   initial begin
      logic [DW-1:0] rd, mrd, held_rd;
      logic          er, mer, held_err;
      int            lat, cyc;
      int            acc_edges[$];

      vecs[0]  = '{1'b1, 5'd3,  64'h2D,                 8'hFF, 64'h0,                 1'b0};
      vecs[1]  = '{1'b0, 5'd3,  64'h0,                  8'h00, 64'h2D,                1'b0};
      vecs[2]  = '{1'b1, 5'd3,  64'hFFFFFFFFFFFFFFFF,   8'h02, 64'h0,                 1'b0};
      vecs[3]  = '{1'b0, 5'd3,  64'h0,                  8'hFF, 64'hFF2D,              1'b0};
      vecs[4]  = '{1'b0, 5'd30, 64'h0,                  8'h00, 64'h0,                 1'b1};
      vecs[5]  = '{1'b1, 5'd25, 64'h11,                 8'hFF, 64'h0,                 1'b1};
      vecs[6]  = '{1'b0, 5'd1,  64'h0,                  8'h00, 64'h0,                 1'b0};
      vecs[7]  = '{1'b1, 5'd5,  64'h0123456789ABCDEF,   8'h00, 64'h0,                 1'b0};
      vecs[8]  = '{1'b0, 5'd5,  64'h0,                  8'h00, 64'h0,                 1'b0};
      vecs[9]  = '{1'b1, 5'd23, 64'hDEADBEEFCAFEF00D,   8'hF0, 64'h0,                 1'b0};
      vecs[10] = '{1'b0, 5'd23, 64'h0,                  8'h00, 64'hDEADBEEF00000000,  1'b0};
      vecs[11] = '{1'b0, 5'd24, 64'h0,                  8'h00, 64'h0,                 1'b1};

      model_clear();

      // Reset state.
      #12;
      check("rst_req_ready", {63'b0, a_req_ready}, 64'd0);
      check("rst_rsp_valid", {63'b0, a_rsp_valid}, 64'd0);
      check("rst_rsp_rdata", a_rsp_rdata, 64'd0);
      check("rst_rsp_err",   {63'b0, a_rsp_err}, 64'd0);
      check("rst_busy",      {63'b0, a_busy}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("ready_after_rst", {63'b0, a_req_ready}, 64'd1);

      // Directed vector table.
      foreach (vecs[i]) begin
         txn_a(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat);
         model_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, mrd, mer);
         check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
         check($sformatf("vec%0d_err", i), {63'b0, er}, {63'b0, vecs[i].exp_err});
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
      end

      // Random traffic against the model.
      for (int n = 0; n < 60; n++) begin
         logic          we;
         logic [AW-1:0] addr;
         logic [DW-1:0] wd;
         logic [7:0]    be;
         we   = 1'($urandom_range(0, 1));
         addr = AW'($urandom_range(0, 31));
         wd   = {$urandom, $urandom};
         be   = 8'($urandom);
         txn_a(we, addr, wd, be, rd, er, lat);
         model_access(we, addr, wd, be, mrd, mer);
         check($sformatf("rnd%0d_rdata", n), rd, mrd);
         check($sformatf("rnd%0d_err", n), {63'b0, er}, {63'b0, mer});
         check($sformatf("rnd%0d_latency", n), 64'(lat), 64'd3);
      end

      // Backpressure: response held, intervening request ignored.
      @(negedge clk);
      a_rsp_ready = 1'b0;
      a_req_valid = 1'b1;
      a_req_we    = 1'b0;
      a_req_addr  = 5'd3;
      @(posedge clk);
      #1;
      a_req_valid = 1'b0;
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
      end while (!a_rsp_valid && cyc < 40);
      check("bp_latency", 64'(cyc), 64'd3);
      model_access(1'b0, 5'd3, 64'h0, 8'h0, mrd, mer);
      held_rd  = a_rsp_rdata;
      held_err = a_rsp_err;
      check("bp_rdata", held_rd, mrd);
      a_req_valid = 1'b1;
      a_req_we    = 1'b1;
      a_req_addr  = 5'd4;
      a_req_wdata = 64'hA5A5A5A5A5A5A5A5;
      a_req_be    = 8'hFF;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("bp%0d_valid", k), {63'b0, a_rsp_valid}, 64'd1);
         check($sformatf("bp%0d_rdata", k), a_rsp_rdata, held_rd);
         check($sformatf("bp%0d_err", k),   {63'b0, a_rsp_err}, {63'b0, held_err});
         check($sformatf("bp%0d_ready", k), {63'b0, a_req_ready}, 64'd0);
         check($sformatf("bp%0d_busy", k),  {63'b0, a_busy}, 64'd1);
      end
      @(negedge clk);
      a_req_valid = 1'b0;
      a_rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_ready", {63'b0, a_req_ready}, 64'd1);
      check("bp_release_valid", {63'b0, a_rsp_valid}, 64'd0);
      txn_a(1'b0, 5'd4, 64'h0, 8'h0, rd, er, lat);
      model_access(1'b0, 5'd4, 64'h0, 8'h0, mrd, mer);
      check("bp_ignored_write", rd, mrd);

      // Reset one edge after accepting a write: write must be dropped.
      @(negedge clk);
      a_req_valid = 1'b1;
      a_req_we    = 1'b1;
      a_req_addr  = 5'd7;
      a_req_wdata = 64'h77;
      a_req_be    = 8'hFF;
      @(posedge clk);
      #1;
      a_req_valid = 1'b0;
      check("mid_busy", {63'b0, a_busy}, 64'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("mid_rst_valid", {63'b0, a_rsp_valid}, 64'd0);
      check("mid_rst_busy",  {63'b0, a_busy}, 64'd0);
      repeat (3) @(posedge clk);
      check("mid_rst_valid_hold", {63'b0, a_rsp_valid}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      #1;
      check("mid_ready_after_rst", {63'b0, a_req_ready}, 64'd1);
      txn_a(1'b0, 5'd7, 64'h0, 8'h0, rd, er, lat);
      check("mid_rd_addr7", rd, 64'h0);
      check("mid_rd_addr7_err", {63'b0, er}, 64'd0);
      txn_a(1'b0, 5'd3, 64'h0, 8'h0, rd, er, lat);
      check("mid_rd_addr3_cleared", rd, 64'h0);

      // Zero wait states (instance b): latency 1 edge.
      @(negedge clk);
      b_req_valid = 1'b1;
      b_req_we    = 1'b0;
      b_req_addr  = 5'd0;
      @(posedge clk);
      #1;
      b_req_valid = 1'b0;
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
      end while (!b_rsp_valid && cyc < 40);
      check("w0_latency", 64'(cyc), 64'd1);
      check("w0_rdata", b_rsp_rdata, 64'h0);
      @(posedge clk);
      #1;

      // Back-to-back requests: acceptance every 3rd edge.
      @(negedge clk);
      b_req_valid = 1'b1;
      b_req_we    = 1'b1;
      b_req_addr  = 5'd9;
      b_req_wdata = 64'h1234;
      b_req_be    = 8'hFF;
      for (int e = 0; e < 13; e++) begin
         logic will_accept;
         will_accept = b_req_ready && b_req_valid;
         @(posedge clk);
         if (will_accept) acc_edges.push_back(e);
         @(negedge clk);
      end
      b_req_valid = 1'b0;
      check("b2b_count", 64'(acc_edges.size()), 64'd5);
      for (int i = 1; i < acc_edges.size(); i++)
         check($sformatf("b2b_gap%0d", i), 64'(acc_edges[i] - acc_edges[i-1]), 64'd3);

      repeat (5) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
